// File: rtl/clk_en_sequencer.sv
// Sequences per-channel clock-forwarding enables: up in ascending order, down in descending order.
// Optional abort support is enabled by defining CLK_EN_SEQUENCER_ABORT_EN.
module clk_en_sequencer #(
  parameter int unsigned N     = 2,
  parameter int unsigned GAP_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_up,
  input  logic             i_down,
  input  logic [N-1:0]     i_mask,
  input  logic [GAP_W-1:0] i_gap,
`ifdef CLK_EN_SEQUENCER_ABORT_EN
  input  logic             i_abort,
  output logic             o_aborted,
`endif
  output logic [N-1:0]     o_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_all_on
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT, S_FIN} state_e;

  state_e           state_q, state_d;
  logic             down_q, down_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             all_on_q, all_on_d;
  logic             aborted_q, aborted_d;
  logic [N-1:0]     pend_c, sel_c, rest_c;

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      down_q    <= 1'b0;
      mask_q    <= '0;
      gap_q     <= '0;
      cnt_q     <= '0;
      en_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      all_on_q  <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      down_q    <= down_d;
      mask_q    <= mask_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      all_on_q  <= all_on_d;
      aborted_q <= aborted_d;
    end
  end

  // Pending channels and the one to toggle next (lowest when going up, highest when going down)
  always_comb begin
    pend_c = down_q ? (mask_q & en_q) : (mask_q & ~en_q);
    sel_c  = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_c[i] && (down_q || (sel_c == '0))) begin
        sel_c    = '0;
        sel_c[i] = 1'b1;
      end
    end
    rest_c = pend_c & ~sel_c;
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    down_d    = down_q;
    mask_d    = mask_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_up || i_down) begin
          down_d  = i_down;
          mask_d  = i_mask;
          gap_d   = i_gap;
          busy_d  = 1'b1;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (pend_c == '0) begin
          state_d = S_FIN;
        end else begin
          en_d = en_q ^ sel_c;
          if (rest_c == '0) begin
            state_d = S_FIN;
          end else if (gap_q != '0) begin
            cnt_d   = gap_q;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= GAP_W'(1)) begin
          state_d = S_STEP;
        end else begin
          cnt_d = cnt_q - GAP_W'(1);
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CLK_EN_SEQUENCER_ABORT_EN
    // Abort beats a coincident toggle: enables stay frozen
    if (i_abort && ((state_q == S_STEP) || (state_q == S_WAIT))) begin
      state_d   = S_IDLE;
      en_d      = en_q;
      cnt_d     = cnt_q;
      busy_d    = 1'b0;
      aborted_d = 1'b1;
    end
`endif
    all_on_d = &en_d;
  end

  assign o_en     = en_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_all_on = all_on_q;
`ifdef CLK_EN_SEQUENCER_ABORT_EN
  assign o_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_clk_en_sequencer.sv
// Randomized self-checking bench for clk_en_sequencer (N=4) against a schedule-based reference model.
module tb_clk_en_sequencer;
  localparam int unsigned N     = 4;
  localparam int unsigned GAP_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_up = 1'b0;
  logic             i_down = 1'b0;
  logic [N-1:0]     i_mask = '0;
  logic [GAP_W-1:0] i_gap = '0;
  logic [N-1:0]     o_en;
  logic             o_busy;
  logic             o_done;
  logic             o_all_on;
`ifdef CLK_EN_SEQUENCER_ABORT_EN
  logic             i_abort = 1'b0;
  logic             o_aborted;
`endif

  int errors = 0;
  int checks = 0;
  logic [N-1:0] model_en = '0;

  always #5 clk = ~clk;

  clk_en_sequencer #(.N(N), .GAP_W(GAP_W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_up     (i_up),
    .i_down   (i_down),
    .i_mask   (i_mask),
    .i_gap    (i_gap),
`ifdef CLK_EN_SEQUENCER_ABORT_EN
    .i_abort  (i_abort),
    .o_aborted(o_aborted),
`endif
    .o_en     (o_en),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_all_on (o_all_on)
  );

  // Reference: toggle j lands at edge 1+j*(gap+1); done follows the last toggle by one edge
  task automatic run_seq(input logic up, input logic down, input logic [N-1:0] mask,
                         input logic [GAP_W-1:0] gap, input bit noise, input string name);
    int order[$];
    logic [N-1:0] pend, exp_en;
    int n, done_edge;
    pend = down ? (mask & model_en) : (mask & ~model_en);
    if (down) begin
      for (int i = N - 1; i >= 0; i--) if (pend[i]) order.push_back(i);
    end else begin
      for (int i = 0; i < N; i++) if (pend[i]) order.push_back(i);
    end
    n = order.size();
    done_edge = (n == 0) ? 2 : 2 + (n - 1) * (int'(gap) + 1);
    @(negedge clk);
    i_up = up; i_down = down; i_mask = mask; i_gap = gap;
    exp_en = model_en;
    for (int e = 0; e <= done_edge + 1; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_en = model_en;
      for (int j = 0; j < n; j++)
        if (1 + j * (int'(gap) + 1) <= e) exp_en[order[j]] = ~exp_en[order[j]];
      checks++;
      if (o_en !== exp_en) begin
        errors++;
        $display("FAIL %s en edge %0d: got %b want %b", name, e, o_en, exp_en);
      end
      checks++;
      if (o_busy !== (e < done_edge)) begin
        errors++;
        $display("FAIL %s busy edge %0d: got %b want %b", name, e, o_busy, (e < done_edge));
      end
      checks++;
      if (o_done !== (e == done_edge)) begin
        errors++;
        $display("FAIL %s done edge %0d: got %b want %b", name, e, o_done, (e == done_edge));
      end
      checks++;
      if (o_all_on !== (exp_en == '1)) begin
        errors++;
        $display("FAIL %s all_on edge %0d: got %b want %b", name, e, o_all_on, (exp_en == '1));
      end
      if (noise && e < done_edge) begin
        i_up = 1'($urandom_range(0, 1)); i_down = 1'($urandom_range(0, 1));
        i_mask = N'($urandom); i_gap = GAP_W'($urandom);
      end else begin
        i_up = 1'b0; i_down = 1'b0;
      end
    end
    model_en = exp_en;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({o_en, o_busy, o_done, o_all_on} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state: got %b want 0000000", {o_en, o_busy, o_done, o_all_on});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_en = '0;
  endtask

  task automatic test_plan();
    run_seq(1'b1, 1'b0, 4'b1111, 8'd2, 1'b0, "up_gap2");
    run_seq(1'b0, 1'b1, 4'b1111, 8'd0, 1'b0, "down_gap0");
    run_seq(1'b1, 1'b0, 4'b1010, 8'd1, 1'b0, "up_mask1010");
    run_seq(1'b0, 1'b1, 4'b1010, 8'd0, 1'b0, "down_mask1010");
  endtask

  task automatic test_both_requests();
    run_seq(1'b1, 1'b0, 4'b0011, 8'd0, 1'b0, "prep_0011");
    run_seq(1'b1, 1'b1, 4'b1111, 8'd1, 1'b1, "both_down_wins");
  endtask

  task automatic test_empty();
    run_seq(1'b1, 1'b0, 4'b0000, 8'd3, 1'b0, "empty_mask");
    run_seq(1'b1, 1'b0, 4'b0110, 8'd0, 1'b0, "prep_0110");
    run_seq(1'b1, 1'b0, 4'b0110, 8'd2, 1'b0, "already_on");
    run_seq(1'b0, 1'b1, 4'b1111, 8'd0, 1'b0, "clear_all");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    i_up = 1'b1; i_mask = 4'b1111; i_gap = 8'd5;
    @(posedge clk);
    @(negedge clk);
    i_up = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_en, o_busy} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: got en=%b busy=%b want 0000/0", o_en, o_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_en = '0;
    run_seq(1'b1, 1'b0, 4'b1111, 8'd1, 1'b0, "after_reset_up");
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic d;
      d = 1'($urandom_range(0, 1));
      run_seq(~d, d, N'($urandom), GAP_W'($urandom_range(0, 3)), 1'b1, "random");
    end
  endtask

`ifdef CLK_EN_SEQUENCER_ABORT_EN
  task automatic test_abort();
    run_seq(1'b0, 1'b1, 4'b1111, 8'd0, 1'b0, "abort_prep");
    @(negedge clk);
    i_up = 1'b1; i_mask = 4'b1111; i_gap = 8'd3;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk);
      @(negedge clk);
      i_up = 1'b0;
    end
    i_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_abort = 1'b0;
    checks++;
    if ({o_aborted, o_busy, o_done} !== 3'b100) begin
      errors++;
      $display("FAIL abort_pulse: got aborted/busy/done=%b want 100", {o_aborted, o_busy, o_done});
    end
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({o_en, o_done, o_aborted} !== {4'b0011, 2'b00}) begin
        errors++;
        $display("FAIL abort_hold: got en=%b done=%b aborted=%b want 0011/0/0", o_en, o_done, o_aborted);
      end
    end
    model_en = 4'b0011;
  endtask
`endif

  initial begin
    test_reset();
    test_plan();
    test_both_requests();
    test_empty();
    test_async_reset();
    test_random();
`ifdef CLK_EN_SEQUENCER_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
